// File: rtl/snake_pkg.sv
// Shared types and constants for the snake position engine.
// Direction/state encodings, HID keycodes and the off-screen parking coordinate.
package snake_pkg;

  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;
  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  localparam int unsigned PARK_POS = 1000;

  function automatic dir_t reverse_dir(dir_t d);
    dir_t r;
    case (d)
      UP:      r = DOWN;
      DOWN:    r = UP;
      LEFT:    r = RIGHT;
      default: r = LEFT;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/snake_body_frame_tick_gen.sv
// Turns the asynchronous vsync into a one-Clk move strobe every MOVE_DIV frames.
// The divider is held at zero whenever the game is not running.
module frame_tick_gen #(
  parameter int unsigned MOVE_DIV = 4
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  input  logic run,
  output logic step
);

  localparam int unsigned DivW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(MOVE_DIV - 1);

  logic            sync1_q, sync2_q, prev_q;
  logic            tick;
  logic [DivW-1:0] div_q;

  assign tick = sync2_q & ~prev_q;
  assign step = run & tick & (div_q == DivLast);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      div_q   <= '0;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (!run) begin
        div_q <= '0;
      end else if (tick) begin
        div_q <= (div_q == DivLast) ? '0 : div_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_body.sv
// Snake head/body position engine: steering, stepping, growth and collision.
// Segment coordinates are registered and packed onto flat buses for the colour mapper.
module snake_body
  import snake_pkg::*;
#(
  parameter int unsigned MAX_SEGS  = 20,
  parameter int unsigned STEP      = 8,
  parameter int unsigned X_LO      = 4,
  parameter int unsigned X_HI      = 636,
  parameter int unsigned Y_LO      = 4,
  parameter int unsigned Y_HI      = 476,
  parameter int unsigned START_X   = 324,
  parameter int unsigned START_Y   = 244,
  parameter int unsigned START_LEN = 2,
  parameter int unsigned MOVE_DIV  = 4,
  parameter int unsigned PARK      = PARK_POS
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     frame_clk,
  input  logic [7:0]               keycode,
  input  logic [9:0]               food_x,
  input  logic [9:0]               food_y,
  output logic [10*MAX_SEGS-1:0]   seg_x,
  output logic [10*MAX_SEGS-1:0]   seg_y,
  output logic [4:0]               seg_len,
  output logic                     food_eaten,
  output logic                     game_over,
  output logic [4:0]               score
);

  localparam logic [9:0] StepV    = 10'(STEP);
  localparam logic [9:0] XLo      = 10'(X_LO);
  localparam logic [9:0] XHi      = 10'(X_HI);
  localparam logic [9:0] YLo      = 10'(Y_LO);
  localparam logic [9:0] YHi      = 10'(Y_HI);
  localparam logic [9:0] StartY   = 10'(START_Y);
  localparam logic [9:0] ParkV    = 10'(PARK);
  localparam logic [4:0] StartLen = 5'(START_LEN);
  localparam logic [4:0] MaxLen   = 5'(MAX_SEGS);

  state_t     state_q;
  dir_t       dir_q, pend_q;
  logic [9:0] sx_q [MAX_SEGS];
  logic [9:0] sy_q [MAX_SEGS];
  logic [4:0] len_q, score_q;
  logic       eaten_q, over_q;

  logic       run, step;
  logic       key_is_dir, key_ok;
  dir_t       key_dir;
  logic [9:0] nx, ny;
  logic       contact, grow, wall_hit, self_hit;
  logic [4:0] new_len;

  assign run = (state_q == RUN);

  frame_tick_gen #(
    .MOVE_DIV(MOVE_DIV)
  ) u_tick (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .frame_clk(frame_clk),
    .run      (run),
    .step     (step)
  );

  function automatic logic [9:0] init_x(int unsigned i);
    return (i < START_LEN) ? 10'(START_X - i * STEP) : ParkV;
  endfunction

  function automatic logic [9:0] init_y(int unsigned i);
    return (i < START_LEN) ? StartY : ParkV;
  endfunction

  always_comb begin
    key_dir    = RIGHT;
    key_is_dir = 1'b1;
    case (keycode)
      KEY_W:   key_dir = UP;
      KEY_S:   key_dir = DOWN;
      KEY_A:   key_dir = LEFT;
      KEY_D:   key_dir = RIGHT;
      default: key_is_dir = 1'b0;
    endcase
  end

  assign key_ok = key_is_dir && (key_dir != reverse_dir(dir_q));

  // Next head uses pending_dir because dir takes it on this same step.
  always_comb begin
    nx = sx_q[0];
    ny = sy_q[0];
    case (pend_q)
      UP:      ny = sy_q[0] - StepV;
      DOWN:    ny = sy_q[0] + StepV;
      LEFT:    nx = sx_q[0] - StepV;
      default: nx = sx_q[0] + StepV;
    endcase
    contact  = (nx == food_x) && (ny == food_y);
    grow     = contact && (len_q < MaxLen);
    wall_hit = (nx < XLo) || (nx > XHi) || (ny < YLo) || (ny > YHi);
    new_len  = grow ? len_q + 5'd1 : len_q;
    self_hit = 1'b0;
    // The tail cell only counts when growing, since otherwise it is vacated.
    for (int i = 1; i < int'(MAX_SEGS); i++) begin
      if ((sx_q[i] == nx) && (sy_q[i] == ny) &&
          ((i <= int'(len_q) - 2) || (grow && (i == int'(len_q) - 1)))) begin
        self_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      dir_q   <= RIGHT;
      pend_q  <= RIGHT;
      len_q   <= StartLen;
      score_q <= '0;
      eaten_q <= 1'b0;
      over_q  <= 1'b0;
      for (int i = 0; i < int'(MAX_SEGS); i++) begin
        sx_q[i] <= init_x(i);
        sy_q[i] <= init_y(i);
      end
    end else begin
      eaten_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (key_is_dir) begin
            state_q <= RUN;
            if (key_ok) pend_q <= key_dir;
          end
        end
        RUN: begin
          if (step) begin
            dir_q <= pend_q;
            if (wall_hit || self_hit) begin
              state_q <= DEAD;
              over_q  <= 1'b1;
            end else begin
              sx_q[0] <= nx;
              sy_q[0] <= ny;
              for (int i = 1; i < int'(MAX_SEGS); i++) begin
                sx_q[i] <= (i < int'(new_len)) ? sx_q[i-1] : ParkV;
                sy_q[i] <= (i < int'(new_len)) ? sy_q[i-1] : ParkV;
              end
              len_q   <= new_len;
              score_q <= new_len - StartLen;
              eaten_q <= contact;
            end
          end else if (key_ok) begin
            pend_q <= key_dir;
          end
        end
        DEAD: begin
          if (keycode == KEY_SPACE) begin
            state_q <= IDLE;
            dir_q   <= RIGHT;
            pend_q  <= RIGHT;
            len_q   <= StartLen;
            score_q <= '0;
            over_q  <= 1'b0;
            for (int i = 0; i < int'(MAX_SEGS); i++) begin
              sx_q[i] <= init_x(i);
              sy_q[i] <= init_y(i);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < int'(MAX_SEGS); g++) begin : g_pack
    assign seg_x[10*g +: 10] = sx_q[g];
    assign seg_y[10*g +: 10] = sy_q[g];
  end

  assign seg_len    = len_q;
  assign score      = score_q;
  assign food_eaten = eaten_q;
  assign game_over  = over_q;

endmodule

// File: tb/tb_snake_body.sv
// Scoreboard bench for snake_body: stimulus queues expected snapshots, the monitor
// pops one each time the visible state (first six slots, length, flags, pulses) changes.
module tb_snake_body;

  localparam int P = 1000;
  localparam logic [7:0] KEY_W = 8'h1A, KEY_A = 8'h04, KEY_S = 8'h16, KEY_D = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  logic         Clk, Reset_n, frame_clk;
  logic [7:0]   keycode;
  logic [9:0]   food_x, food_y;
  logic [199:0] seg_x, seg_y;
  logic [4:0]   seg_len, score;
  logic         food_eaten, game_over;

  snake_body dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .keycode   (keycode),
    .food_x    (food_x),
    .food_y    (food_y),
    .seg_x     (seg_x),
    .seg_y     (seg_y),
    .seg_len   (seg_len),
    .food_eaten(food_eaten),
    .game_over (game_over),
    .score     (score)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [5:0][9:0] x;
    logic [5:0][9:0] y;
    logic [4:0]      len;
    logic            over;
    logic [4:0]      score;
    logic [7:0]      eats;
  } snap_t;

  typedef struct {
    string tag;
    snap_t s;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   timeouts = 0;
  int   exp_eats = 0;
  bit   done = 1'b0;

  function automatic logic [5:0][9:0] pk(input int a0, a1, a2, a3, a4, a5);
    logic [5:0][9:0] r;
    r[0] = 10'(a0); r[1] = 10'(a1); r[2] = 10'(a2);
    r[3] = 10'(a3); r[4] = 10'(a4); r[5] = 10'(a5);
    return r;
  endfunction

  function automatic string fmt(input snap_t s);
    string r;
    r = $sformatf("len=%0d over=%0d score=%0d eats=%0d segs=", s.len, s.over, s.score, s.eats);
    for (int i = 0; i < 6; i++) r = {r, $sformatf("(%0d,%0d)", s.x[i], s.y[i])};
    return r;
  endfunction

  task automatic push(input string tag, input logic [5:0][9:0] xs, input logic [5:0][9:0] ys,
                      input int len, input int over, input int sc);
    exp_t e;
    e.tag     = tag;
    e.s.x     = xs;
    e.s.y     = ys;
    e.s.len   = 5'(len);
    e.s.over  = over[0];
    e.s.score = 5'(sc);
    e.s.eats  = 8'(exp_eats);
    exp_q.push_back(e);
  endtask

  task automatic press(input logic [7:0] code);
    keycode = code;
    repeat (3) @(posedge Clk);
    #1 keycode = 8'h00;
  endtask

  task automatic vsync_edges(input int n);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1'b1;
      repeat (4) @(posedge Clk);
      #1 frame_clk = 1'b0;
      repeat (4) @(posedge Clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge Clk);
    if (exp_q.size() != 0) begin
      timeouts++;
      $display("FAIL %s: timeout, %0d expected updates never seen (required 0 pending)",
               tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_step(input string tag);
    vsync_edges(4);
    wait_drain(tag);
  endtask

  // Monitor: every change of visible state must match the next queued expectation.
  initial begin
    snap_t prev, cur;
    exp_t  e;
    int    eats_seen;
    eats_seen = 0;
    prev = '1;
    while (!done) begin
      @(negedge Clk);
      if (food_eaten) eats_seen++;
      for (int i = 0; i < 6; i++) begin
        cur.x[i] = seg_x[10*i +: 10];
        cur.y[i] = seg_y[10*i +: 10];
      end
      cur.len   = seg_len;
      cur.over  = game_over;
      cur.score = score;
      cur.eats  = 8'(eats_seen);
      if (cur != prev) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_update: got %s, required no change", fmt(cur));
        end else begin
          e = exp_q.pop_front();
          if (e.s != cur) begin
            fails++;
            $display("FAIL %s: got %s, required %s", e.tag, fmt(cur), fmt(e.s));
          end
        end
        prev = cur;
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL final_drain: got %0d pending, required 0", exp_q.size());
    end
    tests++;
    if (timeouts != 0) begin
      fails++;
      $display("FAIL wait_bounds: got %0d timeouts, required 0", timeouts);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0; frame_clk = 1'b0; keycode = 8'h00; food_x = 10'd0; food_y = 10'd0;
    push("reset", pk(324, 316, P, P, P, P), pk(244, 244, P, P, P, P), 2, 0, 0);
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;
    wait_drain("reset");

    // Start with D, first move after four frames.
    press(KEY_D);
    push("first_step", pk(332, 324, P, P, P, P), pk(244, 244, P, P, P, P), 2, 0, 0);
    do_step("first_step");

    // Reverse key ignored, W turns up.
    press(KEY_A);
    press(KEY_W);
    push("steer_up", pk(332, 332, P, P, P, P), pk(236, 244, P, P, P, P), 2, 0, 0);
    do_step("steer_up");

    // Turn right onto food: grow to 3.
    food_x = 10'd340; food_y = 10'd236;
    press(KEY_D);
    exp_eats++;
    push("grow", pk(340, 332, 332, P, P, P), pk(236, 236, 244, P, P, P), 3, 0, 1);
    do_step("grow");
    food_x = 10'd0; food_y = 10'd0;

    // Run to the right wall at x = 636, then one more step dies.
    for (int k = 1; k <= 37; k++) begin
      push("run_right", pk(340 + 8*k, 332 + 8*k, 324 + 8*k, P, P, P),
           pk(236, 236, 236, P, P, P), 3, 0, 1);
      do_step("run_right");
    end
    push("wall_hit", pk(636, 628, 620, P, P, P), pk(236, 236, 236, P, P, P), 3, 1, 1);
    do_step("wall_hit");

    // Dead: keys and frames change nothing.
    press(KEY_D);
    vsync_edges(4);

    push("respawn", pk(324, 316, P, P, P, P), pk(244, 244, P, P, P, P), 2, 0, 0);
    keycode = KEY_SPACE;
    repeat (10) @(posedge Clk);
    #1 keycode = 8'h00;
    wait_drain("respawn");

    // Grow to five, then close a square onto the body.
    food_x = 10'd332; food_y = 10'd244;
    press(KEY_D);
    exp_eats++;
    push("grow3", pk(332, 324, 316, P, P, P), pk(244, 244, 244, P, P, P), 3, 0, 1);
    do_step("grow3");
    food_x = 10'd340;
    exp_eats++;
    push("grow4", pk(340, 332, 324, 316, P, P), pk(244, 244, 244, 244, P, P), 4, 0, 2);
    do_step("grow4");
    food_x = 10'd348;
    exp_eats++;
    push("grow5", pk(348, 340, 332, 324, 316, P), pk(244, 244, 244, 244, 244, P), 5, 0, 3);
    do_step("grow5");
    food_x = 10'd0; food_y = 10'd0;

    press(KEY_D);
    push("loop_d", pk(356, 348, 340, 332, 324, P), pk(244, 244, 244, 244, 244, P), 5, 0, 3);
    do_step("loop_d");
    press(KEY_S);
    push("loop_s", pk(356, 356, 348, 340, 332, P), pk(252, 244, 244, 244, 244, P), 5, 0, 3);
    do_step("loop_s");
    press(KEY_A);
    push("loop_a", pk(348, 356, 356, 348, 340, P), pk(252, 252, 244, 244, 244, P), 5, 0, 3);
    do_step("loop_a");
    press(KEY_W);
    push("self_hit", pk(348, 356, 356, 348, 340, P), pk(252, 252, 244, 244, 244, P), 5, 1, 3);
    do_step("self_hit");

    push("respawn2", pk(324, 316, P, P, P, P), pk(244, 244, P, P, P, P), 2, 0, 0);
    keycode = KEY_SPACE;
    repeat (5) @(posedge Clk);
    #1 keycode = 8'h00;
    wait_drain("respawn2");

    // One step, then reset lands on the tick that would have eaten food.
    press(KEY_D);
    push("pre_reset", pk(332, 324, P, P, P, P), pk(244, 244, P, P, P, P), 2, 0, 0);
    do_step("pre_reset");
    food_x = 10'd340; food_y = 10'd244;
    vsync_edges(3);
    frame_clk = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    #2;
    push("mid_reset", pk(324, 316, P, P, P, P), pk(244, 244, P, P, P, P), 2, 0, 0);
    Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1 frame_clk = 1'b0;
    Reset_n = 1'b1;
    repeat (30) @(posedge Clk);
    wait_drain("mid_reset");
    done = 1'b1;
  end

endmodule

// File: doc/snake_body.md
Name: snake_body

Overview:
- Sequential position engine feeding the colour mapper; owns head/body segment coordinates for the snake.
- Advances the snake one grid cell every MOVE_DIV frames, applies keyboard steering, grows on food contact and detects wall/self collision.
- Drives the per-segment X/Y buses the mapper draws. Segments beyond the current length are parked off-screen so the mapper never draws them.

Parameters:
- MAX_SEGS, 20: segment slots, head = slot 0.
- STEP, 8: pixels per move, equal to 2 × ball size.
- X_LO / X_HI, 4 / 636: legal head-centre X range.
- Y_LO / Y_HI, 4 / 476: legal head-centre Y range.
- START_X / START_Y, 324 / 244: head position after init.
- START_LEN, 2: segments shown after init.
- MOVE_DIV, 4: frame ticks per move step.
- PARK, 1000: X and Y value for inactive slots.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset_n  in  1  asynchronous, active-low reset.
- frame_clk  in  1  VGA vsync, asynchronous to Clk.
- keycode  in  8  current USB HID keycode; 0 = no key.
- food_x  in  10  food centre X, on the STEP grid.
- food_y  in  10  food centre Y, on the STEP grid.
- seg_x  out  10*MAX_SEGS  flattened segment X; slot i at bits [10i+9:10i].
- seg_y  out  10*MAX_SEGS  flattened segment Y, same packing.
- seg_len  out  5  active segment count.
- food_eaten  out  1  one-Clk pulse on food contact; food generator relocates on it.
- game_over  out  1  high while in DEAD.
- score  out  5  seg_len − START_LEN.

Behaviour:
- Clock and reset: one clock, Clk. Reset_n is asynchronous, active-low.
- Reset values:
  - State IDLE, dir = RIGHT, pending_dir = RIGHT.
  - seg[0] = (START_X, START_Y); seg[i] = (START_X − i·STEP, START_Y) for i < START_LEN.
  - All other slots = (PARK, PARK).
  - seg_len = START_LEN, food_eaten = 0, game_over = 0, score = 0, divider = 0.
- Frame tick:
  - frame_clk goes through a 2-flop synchroniser, then rising-edge detect, giving a 1-Clk tick.
  - The divider counts ticks 0..MOVE_DIV−1. step = tick AND divider == MOVE_DIV−1; the divider wraps to 0.
- Keys, sampled every Clk:
  - W 0x1A = UP, S 0x16 = DOWN, A 0x04 = LEFT, D 0x07 = RIGHT.
  - A key loads pending_dir unless it is the exact reverse of dir; a reverse key is ignored.
  - Other codes are ignored, except space 0x2C, which is used only in DEAD.
- States:
  - IDLE: positions frozen, divider held at 0. Any direction key → RUN, with pending_dir loaded; a reverse of RIGHT (LEFT) still starts RUN, but dir stays RIGHT.
  - RUN: on step, dir ← pending_dir and the next head is computed as head ± STEP on one axis.
  - DEAD: everything frozen, game_over = 1. Space → full re-init (identical to reset values), state IDLE. Holding space in IDLE has no effect.
- Step evaluation, all in one Clk, in RUN:
  - grow = (next_head == food) AND seg_len < MAX_SEGS. Compare with exact 10-bit equality.
  - Wall hit: next_head X outside [X_LO, X_HI] or Y outside [Y_LO, Y_HI]. Use unsigned compare; an underflow wrap to ≥ 1000 counts as out of range.
  - Self hit: next_head equals seg[i] for any i in 1..seg_len−2, or for i = seg_len−1 when grow = 1. The tail vacates its cell when not growing.
  - Any hit → DEAD; positions are not updated on that step.
  - Otherwise, shift: seg[i] ← seg[i−1] for i = 1..MAX_SEGS−1, and seg[0] ← next_head.
  - After the shift, slots with index ≥ new seg_len are forced to PARK.
  - If grow: seg_len += 1 and food_eaten = 1 for exactly the following cycle.
- Length saturation: head reaching food at seg_len == MAX_SEGS → no growth, but food_eaten still pulses.
- Output timing: all outputs are registered; the updated positions are visible the Clk after step.
- Reset_n low mid-step: immediate return to reset values; no partial shift persists.

Decomposition:
- Package snake_pkg holds:
  - dir_t enum {UP, DOWN, LEFT, RIGHT}.
  - state_t enum {IDLE, RUN, DEAD}.
  - Keycode constants KEY_W, KEY_A, KEY_S, KEY_D, KEY_SPACE.
  - Constant PARK_POS.
- Sub-module frame_tick_gen: the synchroniser, edge detect and MOVE_DIV divider; outputs step.

Test Plan:
- Reset, then press D, then 4 vsync edges → seg[0] = (332, 244), seg[1] = (324, 244), seg[2] = (1000, 1000), seg_len = 2.
- In RUN heading RIGHT, press A → ignored, dir stays RIGHT. Press W then step → seg[0].y = 236.
- Food at (340, 244), head (332, 244) moving RIGHT, one step → seg_len = 3, food_eaten high exactly 1 Clk, seg[2] = previous seg[1], score = 1.
- Head (636, y) moving RIGHT, step → game_over = 1, positions unchanged. Space → IDLE with reset positions, game_over = 0.
- Grow to length 5, then steer into a square loop (D, S, A, W with one step each) → self hit, DEAD, game_over = 1.
- Assert Reset_n low between tick and step → all outputs return to reset values within the same cycle; no food_eaten pulse.
